// File: rtl/led_switch_arbiter_if.sv
// led_switch_arbiter_if: switch, LED and ownership signals between the PS GPIO side and the arbiter
interface led_switch_arbiter_if;
  logic [3:0] sws_raw_i;
  logic [3:0] sws_db_o;
  logic sws_change_o;
  logic [3:0] sw_leds_i;
  logic sw_leds_en_i;
  logic identify_req_i;
  logic identify_busy_o;
  logic fault_i;
  logic [3:0] leds_4bits_tri_o;
  logic [1:0] grant_o;
  modport master (
    output sws_raw_i, sw_leds_i, sw_leds_en_i, identify_req_i, fault_i,
    input sws_db_o, sws_change_o, identify_busy_o, leds_4bits_tri_o, grant_o
  );
  modport slave (
    input sws_raw_i, sw_leds_i, sw_leds_en_i, identify_req_i, fault_i,
    output sws_db_o, sws_change_o, identify_busy_o, leds_4bits_tri_o, grant_o
  );
endinterface

// File: rtl/led_switch_arbiter.sv
// led_switch_arbiter: debounces user switches and arbitrates LED ownership between fault, identify, software and heartbeat
module led_switch_arbiter #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int BLINK_HALF_CYCLES = 25000000,
  parameter int CHASE_STEP_CYCLES = 12500000,
  parameter int IDENTIFY_STEPS = 16,
  parameter int MIN_HOLD_CYCLES = 1000
) (
  input logic aclk,
  input logic aresetn,
  led_switch_arbiter_if.slave bus
);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BW = BLINK_HALF_CYCLES > 1 ? $clog2(BLINK_HALF_CYCLES) : 1;
  localparam int CW = CHASE_STEP_CYCLES > 1 ? $clog2(CHASE_STEP_CYCLES) : 1;
  localparam int SW = IDENTIFY_STEPS > 1 ? $clog2(IDENTIFY_STEPS) : 1;
  localparam int HW = MIN_HOLD_CYCLES > 1 ? $clog2(MIN_HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_MAX = CW'(CHASE_STEP_CYCLES - 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(IDENTIFY_STEPS - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD_CYCLES - 1);
  typedef enum logic [1:0] {HEARTBEAT, SOFTWARE, IDENTIFY, FAULT} state_t;
  state_t state, next, exit_st;
  logic [3:0] s1, s2, db, upd, chase, leds;
  logic [3:0][DW-1:0] db_cnt;
  logic change, hb_phase, fb_phase, hold_done, step_end, id_done, entry;
  logic [BW-1:0] hb_cnt, fb_cnt;
  logic [CW-1:0] dwell;
  logic [SW-1:0] step;
  logic [HW-1:0] hold;
  always_comb begin
    upd = '0;
    for (int i = 0; i < 4; i++) upd[i] = s2[i] != db[i] && db_cnt[i] == DB_MAX;
  end
  always_ff @(posedge aclk)
    if (!aresetn) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      db_cnt <= '0;
      change <= 1'b0;
    end else begin
      s1 <= bus.sws_raw_i;
      s2 <= s1;
      db <= db ^ upd;
      change <= |upd;
      for (int i = 0; i < 4; i++) db_cnt[i] <= s2[i] == db[i] || upd[i] ? '0 : db_cnt[i] + DW'(1);
    end
  assign hold_done = hold == HOLD_MAX;
  assign step_end = dwell == DWELL_MAX;
  assign id_done = step_end && step == STEP_MAX;
  assign entry = next != state;
  always_comb begin
    exit_st = bus.sw_leds_en_i ? SOFTWARE : HEARTBEAT;
    next = bus.fault_i ? FAULT :
           state == FAULT ? (hold_done ? exit_st : FAULT) :
           state == IDENTIFY ? (id_done ? exit_st : IDENTIFY) :
           bus.identify_req_i ? IDENTIFY :
           hold_done ? exit_st : state;
  end
  always_ff @(posedge aclk)
    if (!aresetn) state <= HEARTBEAT;
    else state <= next;
  // Blink and chase timers run freely outside their state; entry re-arms them.
  always_ff @(posedge aclk)
    if (!aresetn) begin
      hold <= '0;
      hb_cnt <= '0;
      hb_phase <= 1'b0;
      fb_cnt <= '0;
      fb_phase <= 1'b0;
      dwell <= '0;
      step <= '0;
      chase <= '0;
      leds <= '0;
    end else begin
      hold <= entry ? '0 : hold_done ? hold : hold + HW'(1);
      hb_cnt <= hb_cnt == BLINK_MAX ? '0 : hb_cnt + BW'(1);
      hb_phase <= hb_phase ^ (hb_cnt == BLINK_MAX);
      fb_cnt <= entry || fb_cnt == BLINK_MAX ? '0 : fb_cnt + BW'(1);
      fb_phase <= entry ? 1'b0 : fb_phase ^ (fb_cnt == BLINK_MAX);
      dwell <= entry || step_end ? '0 : dwell + CW'(1);
      step <= entry || id_done ? '0 : step + SW'(step_end);
      chase <= entry ? 4'b0001 : step_end ? {chase[2:0], chase[3]} : chase;
      leds <= state == HEARTBEAT ? {3'b000, hb_phase} :
              state == SOFTWARE ? bus.sw_leds_i :
              state == IDENTIFY ? chase : {4{~fb_phase}};
    end
  assign bus.sws_db_o = db;
  assign bus.sws_change_o = change;
  assign bus.leds_4bits_tri_o = leds;
  assign bus.grant_o = state;
  assign bus.identify_busy_o = state == IDENTIFY;
endmodule
